// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file: one synchronous write port, three combinational read ports
//
// Optional feature: define REG_FILE_BYPASS_EN to forward write_data to
// read_data1/read_data2 when the read address matches an accepted write in
// the same cycle. dbg_data always shows the stored value.
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   rst_n        in   asynchronous active-low reset
//   reg_write    in   write enable
//   write_addr   in   destination register (register 0 is hardwired to zero)
//   write_data   in   data to write
//   read_addr1   in   source register for operand a
//   read_addr2   in   source register for operand b
//   read_data1   out  operand a
//   read_data2   out  operand b
//   dbg_addr     in   debug read select
//   dbg_data     out  contents of register dbg_addr (never forwarded)
//   written_mask out  bit i set once register i has been written since reset

module reg_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   localparam int NUM_REGS  = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr1,
   input  logic [ADDR_WIDTH-1:0] read_addr2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data,
   output logic [NUM_REGS-1:0]   written_mask
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  write_en;
   logic [DATA_WIDTH-1:0] stored1;
   logic [DATA_WIDTH-1:0] stored2;
   logic [DATA_WIDTH-1:0] stored_dbg;

   // Address 0 never accepts a write, so regs[0] and written_mask[0] stay 0.
   assign write_en = reg_write && (write_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         written_mask <= '0;
      end else if (write_en) begin
         regs[write_addr]         <= write_data;
         written_mask[write_addr] <= 1'b1;
      end
   end

   always_comb begin
      stored1    = (read_addr1 == '0) ? '0 : regs[read_addr1];
      stored2    = (read_addr2 == '0) ? '0 : regs[read_addr2];
      stored_dbg = (dbg_addr   == '0) ? '0 : regs[dbg_addr];
   end

   // Outputs are forced to zero while reset is held so that a forwarded
   // write_data can never leak out during reset.
   always_comb begin
      read_data1 = '0;
      read_data2 = '0;
      dbg_data   = '0;
      if (rst_n) begin
         dbg_data = stored_dbg;
`ifdef REG_FILE_BYPASS_EN
         read_data1 = (write_en && (read_addr1 == write_addr)) ? write_data : stored1;
         read_data2 = (write_en && (read_addr2 == write_addr)) ? write_data : stored2;
`else
         read_data1 = stored1;
         read_data2 = stored2;
`endif
      end
   end

endmodule
